// File: rtl/switch_bank.sv
`timescale 1ns/1ps
// switch_bank: CH independent edge-triggered on/off switches that gate W-bit data,
// with an optional per-channel auto-off after TIMEOUT cycles in the on state.
module switch_bank #(
  parameter int CH      = 4,
  parameter int W       = 8,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   on,
  input  logic [CH-1:0]   off,
  input  logic [CH*W-1:0] d,
  output logic [CH*W-1:0] q,
  output logic [CH-1:0]   state,
  output logic [CH-1:0]   expired
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CH-1:0] on_prev;
  logic [CH-1:0] off_prev;
  logic [CH-1:0] on_edge;
  logic [CH-1:0] off_edge;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  // Previous values reset to 1 so inputs held high through reset give no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_prev  <= '1;
      off_prev <= '1;
    end else begin
      on_prev  <= on;
      off_prev <= off;
    end
  end

  assign on_edge  = on  & ~on_prev;
  assign off_edge = off & ~off_prev;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic st;
    logic expire_hit;

    if (TIMEOUT > 0) begin : g_timeout
      logic [CW-1:0] cnt;
      logic          exp_r;

      // Any edge in the last on-cycle pre-empts the auto-off.
      assign expire_hit = st && (cnt == CW'(TIMEOUT - 1)) && !on_edge[i] && !off_edge[i];

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt   <= '0;
          exp_r <= 1'b0;
        end else begin
          exp_r <= expire_hit;
          if (!st || on_edge[i] || off_edge[i] || expire_hit) cnt <= '0;
          else                                                cnt <= cnt + CW'(1);
        end
      end

      assign expired[i] = exp_r;
    end else begin : g_no_timeout
      assign expire_hit = 1'b0;
      assign expired[i] = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (rst)                            st <= 1'b0;
      else if (off_edge[i] || expire_hit) st <= 1'b0;
      else if (on_edge[i])                st <= (MODE == 1) ? !st : 1'b1;
    end

    assign state[i]    = st;
    assign q[i*W +: W] = st ? d[i*W +: W] : '0;
  end
endmodule

// File: tb/tb_switch_bank.sv
`timescale 1ns/1ps
// Directed scoreboard bench for switch_bank: four instances cover latch/toggle
// modes with and without auto-off; expectations are queued then checked per cycle.
module tb_switch_bank;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   on_v    [4];
  logic [CH-1:0]   off_v   [4];
  logic [CH*W-1:0] d_v     [4];
  logic [CH*W-1:0] q_w     [4];
  logic [CH-1:0]   state_w [4];
  logic [CH-1:0]   exp_w   [4];

  typedef struct {
    string       tag;
    int          dut;
    int          what;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  // dut0: latch, no timeout; dut1: toggle, no timeout; dut2: latch, TIMEOUT=5; dut3: toggle, TIMEOUT=5
  switch_bank #(.CH(CH), .W(W), .MODE(0), .TIMEOUT(0)) u0 (
    .clk(clk), .rst(rst), .on(on_v[0]), .off(off_v[0]), .d(d_v[0]),
    .q(q_w[0]), .state(state_w[0]), .expired(exp_w[0]));
  switch_bank #(.CH(CH), .W(W), .MODE(1), .TIMEOUT(0)) u1 (
    .clk(clk), .rst(rst), .on(on_v[1]), .off(off_v[1]), .d(d_v[1]),
    .q(q_w[1]), .state(state_w[1]), .expired(exp_w[1]));
  switch_bank #(.CH(CH), .W(W), .MODE(0), .TIMEOUT(5)) u2 (
    .clk(clk), .rst(rst), .on(on_v[2]), .off(off_v[2]), .d(d_v[2]),
    .q(q_w[2]), .state(state_w[2]), .expired(exp_w[2]));
  switch_bank #(.CH(CH), .W(W), .MODE(1), .TIMEOUT(5)) u3 (
    .clk(clk), .rst(rst), .on(on_v[3]), .off(off_v[3]), .d(d_v[3]),
    .q(q_w[3]), .state(state_w[3]), .expired(exp_w[3]));

  function automatic logic [31:0] observe(int dut, int what);
    case (what)
      0:       return {28'b0, state_w[dut]};
      1:       return q_w[dut];
      default: return {28'b0, exp_w[dut]};
    endcase
  endfunction

  task automatic push(string tag, int dut, int what, logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.dut  = dut;
    e.what = what;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic st(string tag, int dut, logic [3:0] v);
    push(tag, dut, 0, {28'b0, v});
  endtask

  task automatic qq(string tag, int dut, logic [31:0] v);
    push(tag, dut, 1, v);
  endtask

  task automatic ex(string tag, int dut, logic [3:0] v);
    push(tag, dut, 2, {28'b0, v});
  endtask

  // Advance one clock, then compare every queued expectation against the outputs.
  task automatic step();
    sb_t         e;
    logic [31:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.dut, e.what);
      n_assert++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s (dut%0d): observed %h expected %h", e.tag, e.dut, obs, e.exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      on_v[k]  = '0;
      off_v[k] = '0;
    end
    d_v[0] = 32'h11A52233;
    d_v[1] = 32'h44556677;
    d_v[2] = 32'h8899AABB;
    d_v[3] = 32'hCCDDEEFF;
    // dut3 holds ON/OFF high through reset: release must not see an edge
    on_v[3]  = 4'hF;
    off_v[3] = 4'hF;

    // ---- reset state
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      st("rst_state", k, 4'h0);
      qq("rst_q", k, 32'h0);
      ex("rst_exp", k, 4'h0);
    end
    step();
    rst = 1'b0;
    st("held_thru_rst", 3, 4'h0);
    step();
    on_v[3]  = '0;
    off_v[3] = '0;
    step();

    // ---- latch and gating (dut0, ch2 data A5)
    on_v[0] = 4'b0100;
    st("latch_on", 0, 4'b0100);
    qq("latch_q", 0, 32'h00A50000);
    step();
    on_v[0] = '0;
    for (int k = 0; k < 6; k++) begin
      st("latch_stays", 0, 4'b0100);
      step();
    end
    d_v[0] = 32'h115A2233;
    qq("latch_q_follow", 0, 32'h005A0000);
    ex("latch_noexp", 0, 4'h0);
    step();
    off_v[0] = 4'b0100;
    st("latch_off", 0, 4'h0);
    qq("latch_q_off", 0, 32'h0);
    step();
    off_v[0] = '0;

    // ---- level-held inputs (dut0, ch0)
    on_v[0] = 4'b0001;
    st("lvl_on", 0, 4'b0001);
    step();
    off_v[0] = 4'b0001;
    st("lvl_off", 0, 4'h0);
    step();
    off_v[0] = '0;
    st("lvl_no_reedge", 0, 4'h0);
    step();
    st("lvl_no_reedge2", 0, 4'h0);
    step();
    on_v[0] = '0;
    step();
    on_v[0] = 4'b0001;
    st("lvl_reedge", 0, 4'b0001);
    step();
    on_v[0]  = '0;
    off_v[0] = 4'b0001;
    st("lvl_clear", 0, 4'h0);
    step();
    off_v[0] = '0;

    // ---- simultaneous ON/OFF while on (dut0 latch, ch1)
    on_v[0] = 4'b0010;
    st("sim0_on", 0, 4'b0010);
    step();
    on_v[0] = '0;
    step();
    on_v[0]  = 4'b0010;
    off_v[0] = 4'b0010;
    st("sim0_off_wins", 0, 4'h0);
    ex("sim0_noexp", 0, 4'h0);
    step();
    on_v[0]  = '0;
    off_v[0] = '0;

    // ---- toggle (dut1, ch0): pulses 4 cycles apart -> 1,0,1
    for (int p = 0; p < 3; p++) begin
      on_v[1] = 4'b0001;
      st("tog_pulse", 1, (p == 1) ? 4'h0 : 4'b0001);
      step();
      on_v[1] = '0;
      for (int k = 0; k < 3; k++) begin
        st("tog_hold", 1, (p == 1) ? 4'h0 : 4'b0001);
        step();
      end
    end
    on_v[1] = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      st("tog_level", 1, 4'h0);
      step();
    end
    on_v[1] = '0;
    step();

    // ---- simultaneous ON/OFF while on (dut1 toggle, ch1)
    on_v[1] = 4'b0010;
    st("sim1_on", 1, 4'b0010);
    step();
    on_v[1] = '0;
    step();
    on_v[1]  = 4'b0010;
    off_v[1] = 4'b0010;
    st("sim1_off_wins", 1, 4'h0);
    ex("sim1_noexp", 1, 4'h0);
    step();
    on_v[1]  = '0;
    off_v[1] = '0;

    // ---- timeout (dut2, ch3): on for exactly 5 cycles, one-cycle EXPIRED
    on_v[2] = 4'b1000;
    st("to_on", 2, 4'b1000);
    qq("to_q", 2, 32'h88000000);
    step();
    on_v[2] = '0;
    for (int k = 0; k < 4; k++) begin
      st("to_run", 2, 4'b1000);
      ex("to_noexp", 2, 4'h0);
      step();
    end
    st("to_expire", 2, 4'h0);
    ex("to_exp_pulse", 2, 4'b1000);
    step();
    ex("to_exp_one", 2, 4'h0);
    step();

    // ---- restart on re-edge: cycle 10 edge, cycle 13 re-edge -> on through 18
    on_v[2] = 4'b1000;
    st("rs_on", 2, 4'b1000);
    step();
    on_v[2] = '0;
    st("rs_c12", 2, 4'b1000);
    step();
    st("rs_c13", 2, 4'b1000);
    step();
    on_v[2] = 4'b1000;
    st("rs_c14", 2, 4'b1000);
    step();
    on_v[2] = '0;
    for (int k = 0; k < 4; k++) begin
      st("rs_run", 2, 4'b1000);
      ex("rs_noexp", 2, 4'h0);
      step();
    end
    st("rs_expire", 2, 4'h0);
    ex("rs_exp_pulse", 2, 4'b1000);
    step();

    // ---- OFF edge in the expiry cycle: clear without EXPIRED
    on_v[2] = 4'b1000;
    ex("eo_exp_clear", 2, 4'h0);
    step();
    on_v[2] = '0;
    for (int k = 0; k < 4; k++) step();
    off_v[2] = 4'b1000;
    st("eo_off", 2, 4'h0);
    ex("eo_noexp", 2, 4'h0);
    step();
    off_v[2] = '0;
    ex("eo_noexp_late", 2, 4'h0);
    step();

    // ---- ON edge in the expiry cycle, latch: restart and stay on
    on_v[2] = 4'b1000;
    step();
    on_v[2] = '0;
    for (int k = 0; k < 4; k++) step();
    on_v[2] = 4'b1000;
    st("eon0_restart", 2, 4'b1000);
    ex("eon0_noexp", 2, 4'h0);
    step();
    on_v[2] = '0;
    for (int k = 0; k < 4; k++) begin
      st("eon0_run", 2, 4'b1000);
      step();
    end
    st("eon0_expire", 2, 4'h0);
    ex("eon0_exp_pulse", 2, 4'b1000);
    step();

    // ---- ON edge in the expiry cycle, toggle (dut3, ch0): off without EXPIRED
    on_v[3] = 4'b0001;
    st("eon1_on", 3, 4'b0001);
    step();
    on_v[3] = '0;
    for (int k = 0; k < 4; k++) begin
      st("eon1_run", 3, 4'b0001);
      step();
    end
    on_v[3] = 4'b0001;
    st("eon1_off", 3, 4'h0);
    ex("eon1_noexp", 3, 4'h0);
    step();
    on_v[3] = '0;
    st("eon1_stay_off", 3, 4'h0);
    ex("eon1_noexp_late", 3, 4'h0);
    step();

    // ---- reset mid-operation with ON/OFF held high
    for (int k = 0; k < 4; k++) on_v[k] = 4'hF;
    for (int k = 0; k < 4; k++) st("mid_all_on", k, 4'hF);
    step();
    step();
    for (int k = 0; k < 4; k++) st("mid_counting", k, 4'hF);
    step();
    for (int k = 0; k < 4; k++) off_v[k] = 4'hF;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      st("mid_rst_state", k, 4'h0);
      qq("mid_rst_q", k, 32'h0);
      ex("mid_rst_exp", k, 4'h0);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) st("mid_rel_noedge", k, 4'h0);
    step();
    for (int k = 0; k < 4; k++) off_v[k] = '0;
    for (int k = 0; k < 4; k++) begin
      st("mid_rel_noedge2", k, 4'h0);
      ex("mid_rel_noexp", k, 4'h0);
    end
    step();
    for (int k = 0; k < 4; k++) on_v[k] = '0;
    step();

    // ---- after reset the timeout runs its full length again (dut2, ch0)
    on_v[2] = 4'b0001;
    step();
    on_v[2] = '0;
    for (int k = 0; k < 4; k++) begin
      st("post_rst_run", 2, 4'b0001);
      step();
    end
    st("post_rst_expire", 2, 4'h0);
    ex("post_rst_exp", 2, 4'b0001);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
